regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_scoreboard.sv | 50 +++++
 rtl/regfile_sb.sv | 119 +++++++++++
 tb/tb_regfile_sb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-bit array: one bit per register, set by issue, cleared by writes.
module regfile_sb_scoreboard #(
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic              fwd_en,
  input  logic              quiet,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP-1:0]    busy
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;

  // Issue is applied after the write clears: a newer producer stays outstanding.
  always_comb begin
    pending_next = pending;
    if (wr0_en) pending_next[wr0_addr] = 1'b0;
    if (wr1_en) pending_next[wr1_addr] = 1'b0;
    if (iss_en) pending_next[iss_addr] = 1'b1;
    if (clr_all) pending_next = '0;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  always_comb begin
    busy = '0;
    for (int p = 0; p < NRP; p++) begin
      busy[p] = pending[rd_addr[p*AW +: AW]];
      if (fwd_en && wr0_en && (wr0_addr == rd_addr[p*AW +: AW])) busy[p] = 1'b0;
      if (fwd_en && wr1_en && (wr1_addr == rd_addr[p*AW +: AW])) busy[p] = 1'b0;
      if (quiet) busy[p] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRP-read register file with pending-bit scoreboard and a
// sequential clear engine that zeroes registers 1..NREG-1 one per cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_addr_i,
  output logic [NRP*XLEN-1:0] rd_data_o,
  output logic [NRP-1:0]      busy_o,
  input  logic                wr0_en_i,
  input  logic [AW-1:0]       wr0_addr_i,
  input  logic [XLEN-1:0]     wr0_data_i,
  input  logic                wr1_en_i,
  input  logic [AW-1:0]       wr1_addr_i,
  input  logic [XLEN-1:0]     wr1_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                clr_req_i,
  output logic                clr_busy_o
);

  logic [XLEN-1:0] regs [NREG];
  clr_state_t      state;
  clr_state_t      state_next;
  logic [AW-1:0]   idx;
  logic            idx_last;
  logic            clear_start;
  logic            wr0_act;
  logic            wr1_act;
  logic            iss_act;
  logic            fwd_en;

  assign idx_last = (idx == AW'(NREG - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req_i) state_next = CLEAR;
      CLEAR:   if (idx_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_busy_o  = (state == CLEAR);
    clear_start = (state == IDLE) && clr_req_i;
  end

  // Index holds at NREG-1 on the final clear cycle rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)                          idx <= '0;
    else if (clear_start)             idx <= AW'(1);
    else if (clr_busy_o && !idx_last) idx <= idx + AW'(1);
  end

  // External traffic is shut out while the clear engine owns the array.
  assign wr0_act = wr0_en_i && !clr_busy_o && (wr0_addr_i != '0);
  assign wr1_act = wr1_en_i && !clr_busy_o && (wr1_addr_i != '0);
  assign iss_act = iss_en_i && !clr_busy_o && (iss_addr_i != '0);
  assign fwd_en  = (BYPASS != 0) && !clr_busy_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (clr_busy_o) begin
      regs[idx] <= '0;
    end else begin
      if (wr0_act) regs[wr0_addr_i] <= wr0_data_i;
      if (wr1_act) regs[wr1_addr_i] <= wr1_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int p = 0; p < NRP; p++) begin
      if (rd_addr_i[p*AW +: AW] == '0)
        rd_data_o[p*XLEN +: XLEN] = '0;
      else if (fwd_en && wr1_act && (wr1_addr_i == rd_addr_i[p*AW +: AW]))
        rd_data_o[p*XLEN +: XLEN] = wr1_data_i;
      else if (fwd_en && wr0_act && (wr0_addr_i == rd_addr_i[p*AW +: AW]))
        rd_data_o[p*XLEN +: XLEN] = wr0_data_i;
      else
        rd_data_o[p*XLEN +: XLEN] = regs[rd_addr_i[p*AW +: AW]];
    end
  end

  regfile_sb_scoreboard #(
    .NREG(NREG),
    .NRP (NRP),
    .AW  (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .clr_all (clear_start),
    .iss_en  (iss_act),
    .iss_addr(iss_addr_i),
    .wr0_en  (wr0_act),
    .wr0_addr(wr0_addr_i),
    .wr1_en  (wr1_act),
    .wr1_addr(wr1_addr_i),
    .fwd_en  (fwd_en),
    .quiet   (clr_busy_o),
    .rd_addr (rd_addr_i),
    .busy    (busy_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a BYPASS=1 and a BYPASS=0 instance share stimulus and
// are compared every cycle against an array-based model, plus directed checks.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRP-1:0]      busy, busy_nb;
  logic                wr0_en, wr1_en, iss_en, clr_req;
  logic [AW-1:0]       wr0_addr, wr1_addr, iss_addr;
  logic [XLEN-1:0]     wr0_data, wr1_data;
  logic                clr_busy, clr_busy_nb;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];
  bit              m_clearing;
  logic [AW-1:0]   m_pos;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .busy_o(busy),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .clr_req_i(clr_req), .clr_busy_o(clr_busy)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .busy_o(busy_nb),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .clr_req_i(clr_req), .clr_busy_o(clr_busy_nb)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit bypass);
    if (a == '0) return '0;
    if (bypass && !m_clearing) begin
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
    end
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit bypass);
    if (a == '0 || m_clearing) return 1'b0;
    if (bypass && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a))) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check_model();
    for (int p = 0; p < NRP; p++) begin
      logic [AW-1:0] a;
      a = rd_addr[p*AW +: AW];
      chk($sformatf("rd%0d_x%0d", p, a), rd_data[p*XLEN +: XLEN], exp_rd(a, 1'b1));
      chk($sformatf("busy%0d_x%0d", p, a), 32'(busy[p]), 32'(exp_busy(a, 1'b1)));
      chk($sformatf("nb_rd%0d_x%0d", p, a), rd_data_nb[p*XLEN +: XLEN], exp_rd(a, 1'b0));
      chk($sformatf("nb_busy%0d_x%0d", p, a), 32'(busy_nb[p]), 32'(exp_busy(a, 1'b0)));
    end
    chk("clr_busy", 32'(clr_busy), 32'(m_clearing));
    chk("nb_clr_busy", 32'(clr_busy_nb), 32'(m_clearing));
  endtask

  // Register-file rules applied at a rising edge, using the inputs held across it.
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_clearing = 1'b0;
      m_pos = '0;
    end else if (m_clearing) begin
      m_regs[m_pos] = '0;
      if (m_pos == AW'(NREG - 1)) m_clearing = 1'b0;
      else m_pos = m_pos + AW'(1);
    end else begin
      if (wr0_en && wr0_addr != '0) begin m_regs[wr0_addr] = wr0_data; m_pend[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != '0) begin m_regs[wr1_addr] = wr1_data; m_pend[wr1_addr] = 1'b0; end
      if (iss_en && iss_addr != '0) m_pend[iss_addr] = 1'b1;
      if (clr_req) begin
        m_clearing = 1'b1;
        m_pos = AW'(1);
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0; wr0_data = '0; wr1_data = '0;
    rd_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    settle();
    edge_step();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NREG; a += 2) begin
      idle_inputs();
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1));
      settle();
      chk($sformatf("%s_x%0d", tag, a), rd_data[XLEN-1:0], 32'h0);
      chk($sformatf("%s_x%0d", tag, a + 1), rd_data[2*XLEN-1:XLEN], 32'h0);
      chk($sformatf("%s_busy", tag), 32'(busy), 32'h0);
      edge_step();
    end
  endtask

  task automatic fill_all();
    for (int i = 1; i < NREG; i += 2) begin
      idle_inputs();
      wr0_en = 1'b1; wr0_addr = AW'(i);     wr0_data = $urandom;
      wr1_en = 1'b1; wr1_addr = AW'(i + 1); wr1_data = $urandom;
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  busy_cycles;
    bit  done;

    for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    m_clearing = 1'b0;
    m_pos = '0;

    idle_inputs();
    rst = 1'b1;
    edge_step();
    edge_step();
    idle_inputs();
    set_rd(0, AW'(5));
    set_rd(1, AW'(31));
    settle();
    chk("reset_clr_busy", 32'(clr_busy), 32'h0);
    chk("reset_x5", rd_data[XLEN-1:0], 32'h0);
    chk("reset_x31", rd_data[2*XLEN-1:XLEN], 32'h0);
    edge_step();

    // Both write ports on x5: port 1 wins.
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = AW'(5); wr0_data = 32'hDEADBEEF;
    wr1_en = 1'b1; wr1_addr = AW'(5); wr1_data = 32'h12345678;
    cycle();
    idle_inputs();
    set_rd(0, AW'(5));
    settle();
    chk("dual_write_x5", rd_data[XLEN-1:0], 32'h12345678);
    chk("dual_write_x5_nb", rd_data_nb[XLEN-1:0], 32'h12345678);
    edge_step();

    // Same-cycle forwarding of wr0 onto a pending register.
    idle_inputs();
    iss_en = 1'b1; iss_addr = AW'(7);
    cycle();
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = AW'(7); wr0_data = 32'hA5A5A5A5;
    set_rd(1, AW'(7));
    settle();
    chk("bypass_x7_data", rd_data[2*XLEN-1:XLEN], 32'hA5A5A5A5);
    chk("bypass_x7_busy", 32'(busy[1]), 32'h0);
    chk("nobypass_x7_data", rd_data_nb[2*XLEN-1:XLEN], 32'h0);
    chk("nobypass_x7_busy", 32'(busy_nb[1]), 32'h1);
    edge_step();
    idle_inputs();
    set_rd(1, AW'(7));
    settle();
    chk("nobypass_x7_next", rd_data_nb[2*XLEN-1:XLEN], 32'hA5A5A5A5);
    edge_step();

    // Issue x9, write two cycles later; then issue and write together.
    idle_inputs();
    iss_en = 1'b1; iss_addr = AW'(9);
    cycle();
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      set_rd(0, AW'(9));
      settle();
      chk($sformatf("x9_pending_c%0d", c), 32'(busy[0]), 32'h1);
      edge_step();
    end
    idle_inputs();
    set_rd(0, AW'(9));
    wr0_en = 1'b1; wr0_addr = AW'(9); wr0_data = 32'h99;
    cycle();
    idle_inputs();
    set_rd(0, AW'(9));
    settle();
    chk("x9_released", 32'(busy[0]), 32'h0);
    edge_step();
    idle_inputs();
    iss_en = 1'b1; iss_addr = AW'(9);
    wr0_en = 1'b1; wr0_addr = AW'(9); wr0_data = 32'h77;
    cycle();
    idle_inputs();
    set_rd(0, AW'(9));
    settle();
    chk("x9_issue_wins", 32'(busy[0]), 32'h1);
    chk("x9_data", rd_data[XLEN-1:0], 32'h77);
    edge_step();

    // Register 0 ignores writes and issues.
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = '0; wr0_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = '0;
    cycle();
    idle_inputs();
    settle();
    chk("x0_data", rd_data[XLEN-1:0], 32'h0);
    chk("x0_busy", 32'(busy[0]), 32'h0);
    chk("x0_data_nb", rd_data_nb[XLEN-1:0], 32'h0);
    edge_step();

    // Full clear: window length, dropped write, zeroed file.
    fill_all();
    idle_inputs();
    iss_en = 1'b1; iss_addr = AW'(12);
    cycle();
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    busy_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      idle_inputs();
      if (c == 5) begin
        wr0_en = 1'b1; wr0_addr = AW'(3); wr0_data = 32'h55;
        iss_en = 1'b1; iss_addr = AW'(4);
        set_rd(0, AW'(3));
      end
      settle();
      if (clr_busy) busy_cycles++;
      else done = 1'b1;
      edge_step();
    end
    chk("clear_done", 32'(done), 32'h1);
    chk("clear_len", 32'(busy_cycles), 32'd31);
    check_all_zero("after_clear");

    // Reset lands on clear cycle 10.
    fill_all();
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    for (int c = 1; c < 10; c++) begin
      idle_inputs();
      cycle();
    end
    idle_inputs();
    rst = 1'b1;
    cycle();
    idle_inputs();
    settle();
    chk("reset_abort_clr_busy", 32'(clr_busy), 32'h0);
    edge_step();
    check_all_zero("after_reset");

    // Randomized traffic, mostly on a few registers so collisions are frequent.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      wr0_en = 1'($urandom_range(0, 1));
      wr1_en = 1'($urandom_range(0, 1));
      iss_en = 1'($urandom_range(0, 2) == 0);
      wr0_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
      wr1_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
      iss_addr = AW'($urandom_range(0, 7));
      wr0_data = $urandom;
      wr1_data = $urandom;
      set_rd(0, AW'($urandom_range(0, 7)));
      set_rd(1, AW'($urandom_range(0, 7)));
      clr_req = 1'($urandom_range(0, 59) == 0);
      rst = 1'($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
